// File: rtl/FPU_pkg.sv
// Shared FPU definitions: operation codes, format encodings and the
// single-precision NaN constants used by the sign-injection stage.
package FPU_pkg;

    typedef enum logic [4:0] {
        FPU_OP_ADD   = 5'd0,
        FPU_OP_SUB   = 5'd1,
        FPU_OP_MUL   = 5'd2,
        FPU_OP_DIV   = 5'd3,
        FPU_OP_SQRT  = 5'd4,
        FPU_OP_SGNJ  = 5'd5,
        FPU_OP_SGNJN = 5'd6,
        FPU_OP_SGNJX = 5'd7,
        FPU_OP_MIN   = 5'd8,
        FPU_OP_MAX   = 5'd9,
        FPU_OP_CVT   = 5'd10,
        FPU_OP_CMP   = 5'd11,
        FPU_OP_CLASS = 5'd12
    } fpu_op_e;

    localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;
    localparam logic [31:0] NAN_BOX     = 32'hFFFF_FFFF;

    localparam logic FMT_S = 1'b0;
    localparam logic FMT_D = 1'b1;

    function automatic logic is_sgnj_op(input logic [4:0] op);
        return (op == FPU_OP_SGNJ) || (op == FPU_OP_SGNJN) || (op == FPU_OP_SGNJX);
    endfunction

    // Sign chosen by the injection flavour; SGNJ is the fallback for any other code.
    function automatic logic injected_sign(input logic [4:0] op, input logic sa, input logic sb);
        case (op)
            FPU_OP_SGNJN: return ~sb;
            FPU_OP_SGNJX: return sa ^ sb;
            default:      return sb;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// Single-entry elastic register carrying a result, its tag and a valid bit.
// The stage is loaded whenever the control chain grants it; flush kills the entry.
module pipe_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [TAG_W-1:0]  tag
);

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= in_valid;
        end
    end

    // NOTE: payload is reset and only captures real entries, so the result port reads 0 until the first result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
            tag  <= '0;
        end else if (load && in_valid && !flush) begin
            data <= in_data;
            tag  <= in_tag;
        end
    end

endmodule

// File: rtl/sign_injection_unit.sv
// FSGNJ/FSGNJN/FSGNJX execution unit: combinational sign injection with
// NaN-boxing checks, followed by an elastic pipeline of STAGES registers.
module sign_injection_unit
    import FPU_pkg::*;
#(
    parameter int FLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             valid_out,
    input  logic             ready_in,
    input  logic [4:0]       op,
    input  logic             fmt,
    input  logic [FLEN-1:0]  a,
    input  logic [FLEN-1:0]  b,
    input  logic [TAG_W-1:0] tag_in,
    output logic [FLEN-1:0]  float_out,
    output logic [TAG_W-1:0] tag_out
);

    logic [FLEN-1:0]  result;
    logic [STAGES-1:0] load;

    // Index 0 is the compute output; index i+1 is the output of stage i.
    logic             stg_valid [STAGES+1];
    logic [FLEN-1:0]  stg_data  [STAGES+1];
    logic [TAG_W-1:0] stg_tag   [STAGES+1];

    if (FLEN == 64) begin : g_dp
        logic [31:0] a_s;
        logic [31:0] b_s;

        always_comb begin
            a_s = (a[63:32] == NAN_BOX) ? a[31:0] : CANON_NAN_S;
            b_s = (b[63:32] == NAN_BOX) ? b[31:0] : CANON_NAN_S;
            if (fmt == FMT_D) begin
                result = {injected_sign(op, a[63], b[63]), a[62:0]};
            end else begin
                result = {NAN_BOX, injected_sign(op, a_s[31], b_s[31]), a_s[30:0]};
            end
        end
    end else begin : g_sp
        // Only the sign of b matters and fmt has no meaning at this width.
        logic unused_sp;
        assign unused_sp = ^{fmt, b[30:0]};
        assign result    = {injected_sign(op, a[31], b[31]), a[30:0]};
    end

    // A stage may load if it or any stage downstream of it is empty, or the sink accepts.
    always_comb begin
        logic can_move;
        can_move = ready_in;
        for (int i = STAGES - 1; i >= 0; i--) begin
            can_move = can_move || !stg_valid[i+1];
            load[i]  = can_move;
        end
    end

    assign stg_valid[0] = valid_in && is_sgnj_op(op);
    assign stg_data[0]  = result;
    assign stg_tag[0]   = tag_in;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_stage #(
            .DATA_W (FLEN),
            .TAG_W  (TAG_W)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .load     (load[i]),
            .in_valid (stg_valid[i]),
            .in_data  (stg_data[i]),
            .in_tag   (stg_tag[i]),
            .valid    (stg_valid[i+1]),
            .data     (stg_data[i+1]),
            .tag      (stg_tag[i+1])
        );
    end

    assign ready_out = load[0];
    assign valid_out = stg_valid[STAGES];
    assign float_out = stg_data[STAGES];
    assign tag_out   = stg_tag[STAGES];

endmodule

// File: tb/tb_sign_injection_unit.sv
// Scoreboard bench for sign_injection_unit: a double-capable 3-stage instance
// and a single-precision 1-stage instance, directed cases plus random traffic.
module tb_sign_injection_unit;
    import FPU_pkg::*;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic flush;

    // Double-capable instance (FLEN=64, STAGES=3)
    logic        d_valid_in, d_ready_out, d_valid_out, d_ready_in, d_fmt;
    logic [4:0]  d_op, d_tag_in, d_tag_out;
    logic [63:0] d_a, d_b, d_float_out;

    // Single-precision instance (FLEN=32, STAGES=1)
    logic        s_valid_in, s_ready_out, s_valid_out, s_ready_in, s_fmt;
    logic [4:0]  s_op, s_tag_in, s_tag_out;
    logic [31:0] s_a, s_b, s_float_out;

    int n_checks = 0;
    int n_fail   = 0;
    int d_out_cnt = 0;
    int s_out_cnt = 0;
    exp_t exp_d[$];
    exp_t exp_s[$];

    sign_injection_unit #(.FLEN(64), .STAGES(3), .TAG_W(5)) u_dp (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_in(d_valid_in), .ready_out(d_ready_out),
        .valid_out(d_valid_out), .ready_in(d_ready_in),
        .op(d_op), .fmt(d_fmt), .a(d_a), .b(d_b), .tag_in(d_tag_in),
        .float_out(d_float_out), .tag_out(d_tag_out)
    );

    sign_injection_unit #(.FLEN(32), .STAGES(1), .TAG_W(5)) u_sp (
        .clk(clk), .reset(reset), .flush(flush),
        .valid_in(s_valid_in), .ready_out(s_ready_out),
        .valid_out(s_valid_out), .ready_in(s_ready_in),
        .op(s_op), .fmt(s_fmt), .a(s_a), .b(s_b), .tag_in(s_tag_in),
        .float_out(s_float_out), .tag_out(s_tag_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic is_sgnj(input logic [4:0] op);
        return op == FPU_OP_SGNJ || op == FPU_OP_SGNJN || op == FPU_OP_SGNJX;
    endfunction

    function automatic logic pick_sign(input logic [4:0] op, input logic sa, input logic sb);
        if (op == FPU_OP_SGNJ)  return sb;
        if (op == FPU_OP_SGNJN) return !sb;
        return sa != sb;
    endfunction

    function automatic logic [31:0] unbox(input logic [63:0] x);
        return (x[63:32] == 32'hFFFF_FFFF) ? x[31:0] : 32'h7FC0_0000;
    endfunction

    function automatic logic [63:0] ref_dp(input logic [4:0] op, input logic fmt,
                                           input logic [63:0] a, input logic [63:0] b);
        logic [31:0] as, bs;
        if (fmt) return {pick_sign(op, a[63], b[63]), a[62:0]};
        as = unbox(a);
        bs = unbox(b);
        return {32'hFFFF_FFFF, pick_sign(op, as[31], bs[31]), as[30:0]};
    endfunction

    function automatic logic [31:0] ref_sp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        return {pick_sign(op, a[31], b[31]), a[30:0]};
    endfunction

    // ---------------- monitors / scoreboards ----------------
    always @(negedge clk) begin
        if (!reset) begin
            exp_d.delete();
        end else begin
            if (d_valid_out) begin
                if (exp_d.size() == 0) begin
                    check("dp_unexpected_valid", 64'(d_valid_out), 64'd0);
                end else begin
                    check("dp_data", d_float_out, exp_d[0].data);
                    check("dp_tag", 64'(d_tag_out), 64'(exp_d[0].tag));
                    if (d_ready_in) void'(exp_d.pop_front());
                end
                if (d_ready_in) d_out_cnt++;
            end
            if (flush) exp_d.delete();
            else if (d_valid_in && d_ready_out && is_sgnj(d_op))
                exp_d.push_back('{ref_dp(d_op, d_fmt, d_a, d_b), d_tag_in});
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            exp_s.delete();
        end else begin
            if (s_valid_out) begin
                if (exp_s.size() == 0) begin
                    check("sp_unexpected_valid", 64'(s_valid_out), 64'd0);
                end else begin
                    check("sp_data", 64'(s_float_out), exp_s[0].data);
                    check("sp_tag", 64'(s_tag_out), 64'(exp_s[0].tag));
                    if (s_ready_in) void'(exp_s.pop_front());
                end
                if (s_ready_in) s_out_cnt++;
            end
            if (flush) exp_s.delete();
            else if (s_valid_in && s_ready_out && is_sgnj(s_op))
                exp_s.push_back('{64'(ref_sp(s_op, s_a, s_b)), s_tag_in});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        d_valid_in = 1'b0; d_ready_in = 1'b1;
        s_valid_in = 1'b0; s_ready_in = 1'b1;
    endtask

    function automatic logic [4:0] rand_op();
        case ($urandom_range(0, 4))
            0:       return FPU_OP_SGNJ;
            1:       return FPU_OP_SGNJN;
            2:       return FPU_OP_SGNJX;
            default: return 5'($urandom());
        endcase
    endfunction

    function automatic logic [63:0] rand_opnd();
        case ($urandom_range(0, 3))
            0:       return {32'hFFFF_FFFF, 32'($urandom())};
            1:       return {32'($urandom()), 32'($urandom())};
            2:       return {32'hFFFF_FFFF, 32'h7FC0_0000 | (32'($urandom()) & 32'h8000_0000)};
            default: return {32'($urandom()), 32'h0};
        endcase
    endfunction

    task automatic rand_drive();
        d_valid_in = ($urandom_range(0, 3) != 0);
        d_op       = rand_op();
        d_fmt      = 1'($urandom_range(0, 1));
        d_a        = rand_opnd();
        d_b        = rand_opnd();
        d_tag_in   = 5'($urandom());
        d_ready_in = ($urandom_range(0, 3) != 0);
        s_valid_in = ($urandom_range(0, 3) != 0);
        s_op       = rand_op();
        s_fmt      = 1'($urandom_range(0, 1));
        s_a        = 32'($urandom());
        s_b        = 32'($urandom());
        s_tag_in   = 5'($urandom());
        s_ready_in = ($urandom_range(0, 3) != 0);
    endtask

    // One op into an empty 3-stage pipe: must appear exactly three cycles later.
    task automatic d_single(input logic [4:0] op, input logic fmt, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] tag,
                            input logic [63:0] exp, input string name);
        d_op = op; d_fmt = fmt; d_a = a; d_b = b; d_tag_in = tag;
        d_valid_in = 1'b1; d_ready_in = 1'b1;
        tick();
        d_valid_in = 1'b0;
        check({name, "_lat1"}, 64'(d_valid_out), 64'd0);
        tick();
        check({name, "_lat2"}, 64'(d_valid_out), 64'd0);
        tick();
        check({name, "_valid"}, 64'(d_valid_out), 64'd1);
        check({name, "_data"}, d_float_out, exp);
        check({name, "_tag"}, 64'(d_tag_out), 64'(tag));
        tick();
    endtask

    task automatic s_single(input logic [4:0] op, input logic fmt, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] tag,
                            input logic [31:0] exp, input string name);
        s_op = op; s_fmt = fmt; s_a = a; s_b = b; s_tag_in = tag;
        s_valid_in = 1'b1; s_ready_in = 1'b1;
        tick();
        s_valid_in = 1'b0;
        check({name, "_valid"}, 64'(s_valid_out), 64'd1);
        check({name, "_data"}, 64'(s_float_out), 64'(exp));
        check({name, "_tag"}, 64'(s_tag_out), 64'(tag));
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, acc, cnt0;
        logic rdy;

        reset = 1'b0; flush = 1'b0;
        idle();
        d_op = FPU_OP_SGNJ; d_fmt = 1'b0; d_a = '0; d_b = '0; d_tag_in = '0;
        s_op = FPU_OP_SGNJ; s_fmt = 1'b0; s_a = '0; s_b = '0; s_tag_in = '0;
        repeat (3) tick();
        check("rst_dp_valid", 64'(d_valid_out), 64'd0);
        check("rst_dp_float", d_float_out, 64'd0);
        check("rst_dp_tag", 64'(d_tag_out), 64'd0);
        check("rst_sp_valid", 64'(s_valid_out), 64'd0);
        check("rst_sp_float", 64'(s_float_out), 64'd0);
        check("rst_sp_tag", 64'(s_tag_out), 64'd0);
        reset = 1'b1;
        repeat (2) tick();
        check("post_rst_dp_ready", 64'(d_ready_out), 64'd1);
        check("post_rst_sp_ready", 64'(s_ready_out), 64'd1);
        check("post_rst_dp_float", d_float_out, 64'd0);

        // Single precision basics, fmt=1 ignored at FLEN=32
        s_single(FPU_OP_SGNJ,  1'b0, 32'h3F80_0000, 32'h8000_0000, 5'd1, 32'hBF80_0000, "sp_sgnj");
        s_single(FPU_OP_SGNJN, 1'b0, 32'h3F80_0000, 32'h8000_0000, 5'd2, 32'h3F80_0000, "sp_sgnjn");
        s_single(FPU_OP_SGNJX, 1'b0, 32'hBF80_0000, 32'h8000_0000, 5'd3, 32'h3F80_0000, "sp_sgnjx");
        s_single(FPU_OP_SGNJ,  1'b1, 32'h3F80_0000, 32'h8000_0000, 5'd4, 32'hBF80_0000, "sp_fmt_ignored");

        // NaN-boxing and double precision
        d_single(FPU_OP_SGNJ, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_8000_0000, 5'd6,
                 64'hFFFF_FFFF_FFC0_0000, "dp_unboxed_a");
        d_single(FPU_OP_SGNJ, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'hFFFF_FFFF_8000_0000, 5'd7,
                 64'hFFFF_FFFF_BF80_0000, "dp_boxed_a");
        d_single(FPU_OP_SGNJN, 1'b0, 64'hFFFF_FFFF_3F80_0000, 64'h1234_5678_0000_0000, 5'd8,
                 64'hFFFF_FFFF_BF80_0000, "dp_unboxed_b");
        d_single(FPU_OP_SGNJX, 1'b1, 64'hC000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd9,
                 64'h4000_0000_0000_0000, "dp_double_sgnjx");

        // Backpressure: 3 accepts fill the pipe, then release and drain tags 1..5
        cnt0 = d_out_cnt;
        d_ready_in = 1'b0; k = 1; acc = 0;
        for (int c = 0; c < 6; c++) begin
            d_valid_in = 1'b1; d_op = FPU_OP_SGNJX; d_fmt = 1'b0;
            d_a = {32'hFFFF_FFFF, 32'($urandom())}; d_b = rand_opnd(); d_tag_in = 5'(k);
            #1 rdy = d_ready_out;
            tick();
            if (rdy) begin acc++; k++; end
        end
        check("stall_accepts", 64'(acc), 64'd3);
        check("stall_ready_low", 64'(d_ready_out), 64'd0);
        check("stall_valid_held", 64'(d_valid_out), 64'd1);
        check("stall_head_tag", 64'(d_tag_out), 64'd1);
        d_ready_in = 1'b1;
        #1 check("full_pipe_ready_on_release", 64'(d_ready_out), 64'd1);
        for (int c = 0; c < 10 && k <= 5; c++) begin
            d_valid_in = 1'b1; d_tag_in = 5'(k);
            d_a = rand_opnd(); d_b = rand_opnd();
            #1 rdy = d_ready_out;
            tick();
            if (rdy) k++;
        end
        d_valid_in = 1'b0;
        repeat (6) tick();
        check("stall_drain_count", 64'(d_out_cnt - cnt0), 64'd5);

        // Non-sign-injection op is never accepted
        cnt0 = d_out_cnt;
        d_op = FPU_OP_ADD; d_valid_in = 1'b1; d_ready_in = 1'b1;
        repeat (8) begin
            tick();
            check("add_ignored_valid", 64'(d_valid_out), 64'd0);
        end
        d_valid_in = 1'b0;
        check("add_ignored_count", 64'(d_out_cnt - cnt0), 64'd0);

        // Flush with three entries in flight, plus an op offered in the flush cycle
        d_ready_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            d_valid_in = 1'b1; d_op = FPU_OP_SGNJ; d_fmt = 1'b1;
            d_a = rand_opnd(); d_b = rand_opnd(); d_tag_in = 5'(10 + c);
            tick();
        end
        check("pre_flush_valid", 64'(d_valid_out), 64'd1);
        cnt0 = d_out_cnt;
        flush = 1'b1; d_tag_in = 5'd20;
        tick();
        flush = 1'b0; d_valid_in = 1'b0;
        check("flush_valid_out", 64'(d_valid_out), 64'd0);
        d_ready_in = 1'b1;
        repeat (6) begin
            tick();
            check("post_flush_quiet", 64'(d_valid_out), 64'd0);
        end
        check("post_flush_count", 64'(d_out_cnt - cnt0), 64'd0);

        // Random traffic on both instances
        repeat (1500) begin
            rand_drive();
            tick();
        end

        // Reset in the middle of a stream
        repeat (20) begin
            rand_drive();
            d_valid_in = 1'b1; d_op = FPU_OP_SGNJ; d_ready_in = 1'b1;
            s_valid_in = 1'b1; s_op = FPU_OP_SGNJN; s_ready_in = 1'b1;
            tick();
        end
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_rst_dp_valid", 64'(d_valid_out), 64'd0);
        check("async_rst_dp_float", d_float_out, 64'd0);
        check("async_rst_dp_tag", 64'(d_tag_out), 64'd0);
        check("async_rst_sp_valid", 64'(s_valid_out), 64'd0);
        check("async_rst_sp_float", 64'(s_float_out), 64'd0);
        check("async_rst_sp_tag", 64'(s_tag_out), 64'd0);
        idle();
        repeat (2) tick();
        reset = 1'b1;
        repeat (8) begin
            tick();
            check("post_rst_dp_quiet", 64'(d_valid_out), 64'd0);
            check("post_rst_sp_quiet", 64'(s_valid_out), 64'd0);
        end
        check("post_rst_dp_float_zero", d_float_out, 64'd0);
        check("post_rst_sp_float_zero", 64'(s_float_out), 64'd0);

        // Short random burst after reset, then drain
        repeat (200) begin
            rand_drive();
            tick();
        end
        idle();
        repeat (10) tick();
        check("dp_scoreboard_empty", 64'(exp_d.size()), 64'd0);
        check("sp_scoreboard_empty", 64'(exp_s.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sign_injection_unit.md
Name: sign_injection_unit

Overview:
Parametrised sign-injection stage of the FPU, executing FSGNJ/FSGNJN/FSGNJX for single precision and optionally double precision.
- Adds NaN-boxing checks, a tag sideband, a synchronous flush and a configurable elastic pipeline with full backpressure.
- Sits beside the other FPU execution units behind the FPU operation dispatcher.
- Ignores every operation that is not a sign-injection operation.

Parameters:
FLEN, 32, FP register width; legal values are 32 and 64.
STAGES, 1, number of pipeline register stages (1..4); this is the latency in cycles.
TAG_W, 5, width of the opaque tag (e.g. destination register index) carried alongside each result.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all in-flight operations
valid_in  in  1  upstream operation valid
ready_out  out  1  unit can accept an operation this cycle
valid_out  out  1  result valid
ready_in  in  1  downstream accepts result
op  in  5  FPU operation code; FPU_OP_SGNJ, FPU_OP_SGNJN and FPU_OP_SGNJX are acted on
fmt  in  1  0 = single precision, 1 = double precision (FLEN=64 only)
a  in  FLEN  magnitude source operand
b  in  FLEN  sign source operand
tag_in  in  TAG_W  sideband tag
float_out  out  FLEN  result
tag_out  out  TAG_W  tag of the result

Behaviour:
- Reset (asynchronous, reset=0): every stage valid cleared. valid_out=0, float_out=0, tag_out=0.
- Accept: transfer occurs when valid_in && ready_out && op is one of the three SGNJ ops. Any other op is never accepted and has no effect.
- Elastic pipeline: stage i holds one entry. Stage i can load when it is empty or stage i+1 can load. The last stage can load when it is empty or ready_in=1.
  - ready_out = load-enable of stage 0.
  - Bubbles collapse.
  - Throughput 1 op/cycle with no stalls; latency exactly STAGES cycles from accept to valid_out.
- Stall: when valid_out && !ready_in, float_out and tag_out stay constant and no entry is lost or duplicated.
- Compute (combinational, before stage 0):
  - Single precision (fmt=0): operands use bits [31:0], sa=a[31], sb=b[31].
  - Double precision (fmt=1, FLEN=64 only): sa=a[63], sb=b[63].
  - SGNJ: sign=sb. SGNJN: sign=!sb. SGNJX: sign=sa^sb. Magnitude bits are passed through from a.
- NaN-boxing (FLEN=64, fmt=0):
  - An operand whose bits [63:32] are not all ones is treated as the canonical NaN 32'h7FC00000 before injection.
  - The result is NaN-boxed: bits [63:32] = 32'hFFFFFFFF.
- FLEN=32: fmt is ignored and treated as 0; no boxing.
- fmt=1 with FLEN=32 is treated as fmt=0.
- No exception flags; sign injection raises nothing.
- Flush: on the next edge all stage valids clear and valid_out=0. Inputs presented in the flush cycle are discarded even if valid_in && ready_out.
- Flush together with reset: reset dominates.
- Accept and output handshake in the same cycle on a full pipeline: legal, and occupancy is unchanged.
- Reset mid-operation: in-flight entries are lost; the unit must not emit a spurious valid_out after reset release.
- Result data of empty stages is don't-care, except that float_out and tag_out read 0 after reset until the first result.

Decomposition:
- FPU_pkg holds the shared definitions:
  - existing FPU_OP_SGNJ / FPU_OP_SGNJN / FPU_OP_SGNJX
  - new constants CANON_NAN_S = 32'h7FC00000 and NAN_BOX = 32'hFFFFFFFF
  - fmt encoding constants FMT_S=0, FMT_D=1
- One sub-module, pipe_stage: a parametrised single-entry elastic register holding data, tag and valid, with flush. It is instantiated STAGES times in a generate loop.
- The compute logic stays in the top module.

Test Plan:
1. FLEN=32, STAGES=1: SGNJ a=0x3F800000, b=0x80000000 -> float_out=0xBF800000 one cycle later. SGNJN with the same operands -> 0x3F800000. SGNJX a=0xBF800000, b=0x80000000 -> 0x3F800000.
2. FLEN=64, fmt=0: a=0x00000000_3F800000 (not boxed), b=0xFFFFFFFF_80000000, SGNJ -> 0xFFFFFFFF_FFC00000. Boxed a=0xFFFFFFFF_3F800000 -> 0xFFFFFFFF_BF800000.
3. FLEN=64, fmt=1: SGNJX a=0xC000000000000000, b=0x8000000000000000 -> 0x4000000000000000.
4. STAGES=3, ready_in held 0, 5 back-to-back ops with tags 1..5:
   - ready_out drops after 3 accepts.
   - Releasing ready_in yields tags 1..5 in order, no loss or duplication, and float_out stable during the stall.
5. Op FPU_OP_ADD with valid_in=1 -> no valid_out ever.
6. Flush with 3 in flight -> valid_out=0 next cycle and no further results.
7. Assert reset mid-stream -> all outputs 0 immediately (asynchronous), with no spurious valid_out after reset release.
